// File: rtl/snitch_vfpr_pkg.sv
// Shared definitions for the banked vector FP register file front-end.
// Provides the statistics counter width, default request/response structs
// (64-bit data, 32-bit byte address, 5-bit bank row) and the address
// decode helpers that split a byte address into bank index and bank row.
package snitch_vfpr_pkg;

    localparam int unsigned CntWidth = 32;

    // Default port-side request/response (TCDM style).
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [63:0] data;
        logic [7:0]  strb;
    } vfpr_tcdm_req_chan_t;

    typedef struct packed {
        logic                q_valid;
        vfpr_tcdm_req_chan_t q;
    } vfpr_tcdm_req_t;

    typedef struct packed {
        logic [63:0] data;
    } vfpr_rsp_chan_t;

    typedef struct packed {
        logic           q_ready;
        logic           p_valid;
        vfpr_rsp_chan_t p;
    } vfpr_tcdm_rsp_t;

    // Default bank-side request/response (single-port SRAM).
    typedef struct packed {
        logic [4:0]  addr;
        logic        write;
        logic [63:0] data;
        logic [7:0]  strb;
    } vfpr_mem_req_chan_t;

    typedef struct packed {
        logic               q_valid;
        vfpr_mem_req_chan_t q;
    } vfpr_mem_req_t;

    typedef struct packed {
        logic           q_ready;
        vfpr_rsp_chan_t p;
    } vfpr_mem_rsp_t;

    // Bank index: word-interleaved, the bits right above the byte offset.
    // With a single bank the mask is zero, so the result is always 0.
    function automatic logic [31:0] bank_idx(input logic [63:0] addr,
                                             input int unsigned byte_off,
                                             input int unsigned num_banks);
        logic [63:0] sh;
        sh = addr >> byte_off;
        return sh[31:0] & (num_banks - 1);
    endfunction

    // Bank row: the row_width bits above the bank select field.
    function automatic logic [63:0] row_idx(input logic [63:0] addr,
                                            input int unsigned shift,
                                            input int unsigned row_width);
        logic [63:0] sh;
        logic [63:0] mask;
        sh   = addr >> shift;
        mask = (64'd1 << row_width) - 64'd1;
        return sh & mask;
    endfunction

endpackage

// File: rtl/snitch_vfpr_bank_arb.sv
// Per-bank round-robin arbiter with fixed-latency response tag pipeline.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   cand_i        : one bit per port requesting this bank
//   mem_ready_i   : bank accepts a request this cycle
//   gnt_o         : one-hot winner (independent of mem_ready_i)
//   valid_o       : some port requests this bank
//   winner_o      : index of the winning port
//   rsp_valid_o   : a response leaves the tag pipeline this cycle
//   rsp_port_o    : port that response belongs to
// Handshake: a request is accepted in the cycle valid_o & mem_ready_i;
// only then does the priority pointer move and a tag enter the pipeline.
module snitch_vfpr_bank_arb #(
    parameter int unsigned NumPorts   = 2,
    parameter int unsigned MemLatency = 1,
    localparam int unsigned PortW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumPorts-1:0] cand_i,
    input  logic                mem_ready_i,
    output logic [NumPorts-1:0] gnt_o,
    output logic                valid_o,
    output logic [PortW-1:0]    winner_o,
    output logic                rsp_valid_o,
    output logic [PortW-1:0]    rsp_port_o
);

    logic [PortW-1:0] rr_ptr_q, rr_ptr_d;
    logic             tag_valid_q [MemLatency];
    logic             tag_valid_d [MemLatency];
    logic [PortW-1:0] tag_port_q  [MemLatency];
    logic [PortW-1:0] tag_port_d  [MemLatency];
    logic             handshake;

    // First candidate at or after rr_ptr_q, wrapping modulo NumPorts.
    always_comb begin
        int  idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        gnt_o    = '0;
        winner_o = '0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= int'(NumPorts)) idx = idx - int'(NumPorts);
            if (!found && cand_i[idx]) begin
                found    = 1'b1;
                winner_o = PortW'(idx);
            end
        end
        if (found) gnt_o[winner_o] = 1'b1;
    end

    assign valid_o   = |cand_i;
    assign handshake = valid_o & mem_ready_i;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (handshake) begin
            rr_ptr_d = (winner_o == PortW'(NumPorts - 1)) ? '0 : winner_o + 1'b1;
        end
    end

    always_comb begin
        tag_valid_d[0] = handshake;
        tag_port_d[0]  = winner_o;
        for (int s = 1; s < int'(MemLatency); s++) begin
            tag_valid_d[s] = tag_valid_q[s-1];
            tag_port_d[s]  = tag_port_q[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            for (int s = 0; s < int'(MemLatency); s++) begin
                tag_valid_q[s] <= 1'b0;
                tag_port_q[s]  <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int s = 0; s < int'(MemLatency); s++) begin
                tag_valid_q[s] <= tag_valid_d[s];
                tag_port_q[s]  <= tag_port_d[s];
            end
        end
    end

    assign rsp_valid_o = tag_valid_q[MemLatency-1];
    assign rsp_port_o  = tag_port_q[MemLatency-1];

endmodule

// File: rtl/snitch_vfpr_banked.sv
// Banked vector FP register file front-end: NumPorts TCDM requesters share
// NumBanks single-port SRAM banks, word-interleaved.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   req_i / rsp_o  : per-port request and response
//   mem_req_o / mem_rsp_i : per-bank SRAM request and response
//   clr_stats_i    : synchronous clear of the conflict counter
//   conflict_cnt_o : saturating count of cycles with a lost arbitration
// Handshake: a port request is taken in the cycle q_valid & q_ready; the
// requester keeps it stable until then. Each accepted request returns
// exactly one p_valid on the same port MemLatency cycles later, without
// backpressure.
module snitch_vfpr_banked
    import snitch_vfpr_pkg::*;
#(
    parameter int unsigned NumPorts     = 2,
    parameter int unsigned NumBanks     = 4,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned MemAddrWidth = 5,
    parameter int unsigned MemLatency   = 1,
    parameter type tcdm_req_t = snitch_vfpr_pkg::vfpr_tcdm_req_t,
    parameter type tcdm_rsp_t = snitch_vfpr_pkg::vfpr_tcdm_rsp_t,
    parameter type mem_req_t  = snitch_vfpr_pkg::vfpr_mem_req_t,
    parameter type mem_rsp_t  = snitch_vfpr_pkg::vfpr_mem_rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  tcdm_req_t           req_i     [NumPorts],
    output tcdm_rsp_t           rsp_o     [NumPorts],
    output mem_req_t            mem_req_o [NumBanks],
    input  mem_rsp_t            mem_rsp_i [NumBanks],
    input  logic                clr_stats_i,
    output logic [CntWidth-1:0] conflict_cnt_o
);

    localparam int unsigned ByteOff = $clog2(DataWidth / 8);
    localparam int unsigned BankSel = $clog2(NumBanks);
    localparam int unsigned BankW   = (NumBanks > 1) ? BankSel : 1;
    localparam int unsigned PortW   = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [BankW-1:0]        bank_sel   [NumPorts];
    logic [MemAddrWidth-1:0] row        [NumPorts];
    logic [NumPorts-1:0]     cand       [NumBanks];
    logic [NumPorts-1:0]     gnt        [NumBanks];
    logic                    bank_valid [NumBanks];
    logic [PortW-1:0]        winner     [NumBanks];
    logic                    rsp_valid  [NumBanks];
    logic [PortW-1:0]        rsp_port   [NumBanks];
    logic                    conflict;
    logic [CntWidth-1:0]     conflict_cnt_q, conflict_cnt_d;

    // Address decode; bits above the row field are ignored.
    always_comb begin
        for (int p = 0; p < int'(NumPorts); p++) begin
            bank_sel[p] = BankW'(bank_idx(64'(req_i[p].q.addr), ByteOff, NumBanks));
            row[p]      = MemAddrWidth'(row_idx(64'(req_i[p].q.addr), ByteOff + BankSel,
                                                MemAddrWidth));
        end
    end

    always_comb begin
        for (int b = 0; b < int'(NumBanks); b++) begin
            for (int p = 0; p < int'(NumPorts); p++) begin
                cand[b][p] = req_i[p].q_valid && (bank_sel[p] == BankW'(b));
            end
        end
    end

    for (genvar b = 0; b < int'(NumBanks); b++) begin : g_bank
        snitch_vfpr_bank_arb #(
            .NumPorts  (NumPorts),
            .MemLatency(MemLatency)
        ) i_arb (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .cand_i     (cand[b]),
            .mem_ready_i(mem_rsp_i[b].q_ready),
            .gnt_o      (gnt[b]),
            .valid_o    (bank_valid[b]),
            .winner_o   (winner[b]),
            .rsp_valid_o(rsp_valid[b]),
            .rsp_port_o (rsp_port[b])
        );
    end

    // Forward the winner's request to its bank, address replaced by row.
    always_comb begin
        for (int b = 0; b < int'(NumBanks); b++) begin
            mem_req_o[b]         = '0;
            mem_req_o[b].q_valid = bank_valid[b];
            mem_req_o[b].q.addr  = row[winner[b]];
            mem_req_o[b].q.write = req_i[winner[b]].q.write;
            mem_req_o[b].q.data  = req_i[winner[b]].q.data;
            mem_req_o[b].q.strb  = req_i[winner[b]].q.strb;
        end
    end

    // Uniform latency and one request per port per cycle mean at most one
    // bank returns to a given port in any cycle, so OR-ing is safe.
    always_comb begin
        for (int p = 0; p < int'(NumPorts); p++) begin
            rsp_o[p]         = '0;
            rsp_o[p].q_ready = gnt[bank_sel[p]][p] && mem_rsp_i[bank_sel[p]].q_ready;
            for (int b = 0; b < int'(NumBanks); b++) begin
                if (rsp_valid[b] && (rsp_port[b] == PortW'(p))) begin
                    rsp_o[p].p_valid = 1'b1;
                    rsp_o[p].p.data  = mem_rsp_i[b].p.data;
                end
            end
        end
    end

    // A conflict is a valid request that lost arbitration; stalls caused
    // purely by a busy bank are not counted.
    always_comb begin
        conflict = 1'b0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            if (req_i[p].q_valid && !gnt[bank_sel[p]][p]) conflict = 1'b1;
        end
    end

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (clr_stats_i) begin
            conflict_cnt_d = '0;
        end else if (conflict && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_snitch_vfpr_banked.sv
// Bench for snitch_vfpr_banked (2 ports, 4 banks, 64-bit, latency 1).
// Directed scenarios followed by random traffic, all checked against a
// word-addressed reference model of the register file.
module tb_snitch_vfpr_banked;
    import snitch_vfpr_pkg::*;

    localparam int NP = 2;
    localparam int NB = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vfpr_tcdm_req_t req  [NP];
    vfpr_tcdm_rsp_t rsp  [NP];
    vfpr_mem_req_t  mreq [NB];
    vfpr_mem_rsp_t  mrsp [NB];
    logic           clr;
    logic [31:0]    cnt;

    snitch_vfpr_banked #(
        .NumPorts(NP), .NumBanks(NB), .DataWidth(64), .MemAddrWidth(5), .MemLatency(1)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .rsp_o         (rsp),
        .mem_req_o     (mreq),
        .mem_rsp_i     (mrsp),
        .clr_stats_i   (clr),
        .conflict_cnt_o(cnt)
    );

    // ---------------- reference model state ----------------
    int          rr_m [NB];         // next port with priority per bank
    logic [31:0] cnt_m;
    logic [63:0] shadow [128];      // register file by word address
    logic [63:0] sram [NB][32];     // bank storage seen by the DUT
    logic [65:0] exp_q[$];          // {port, is_write, read data}
    logic        last_rdy [NP];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int m_bank(input logic [31:0] a);
        return int'((a / 8) % NB);
    endfunction

    function automatic logic [63:0] m_row(input logic [31:0] a);
        return 64'((a / 32) % 32);
    endfunction

    function automatic int m_word(input logic [31:0] a);
        return int'((a / 8) % 128);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int k = 0; k < 8; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic w,
                           input logic [63:0] d, input logic [7:0] s);
        req[p].q_valid = v;
        req[p].q.addr  = a;
        req[p].q.write = w;
        req[p].q.data  = d;
        req[p].q.strb  = s;
    endtask

    task automatic idle();
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, 32'h0, 1'b0, 64'h0, 8'h0);
    endtask

    // One clock cycle: entered and left at the falling edge with inputs set.
    task automatic step();
        int          win [NB];
        int          b, w, wd, p;
        logic        exp_rdy, any_conf;
        logic        cap_v [NB];
        logic        cap_wr [NB];
        logic        cap_rdy [NB];
        logic [4:0]  cap_row [NB];
        logic [63:0] cap_d [NB];
        logic [7:0]  cap_s [NB];
        logic [63:0] out_d [NB];
        int          ev_n [NP];
        logic        ew [NP];
        logic [63:0] ed [NP];
        logic [65:0] e;
        #1;
        for (int bb = 0; bb < NB; bb++) begin
            win[bb] = -1;
            for (int i = 0; i < NP; i++) begin
                p = (rr_m[bb] + i) % NP;
                if (win[bb] < 0 && req[p].q_valid && m_bank(req[p].q.addr) == bb) win[bb] = p;
            end
        end
        any_conf = 1'b0;
        for (int pp = 0; pp < NP; pp++) begin
            b = m_bank(req[pp].q.addr);
            exp_rdy = req[pp].q_valid && (win[b] == pp) && mrsp[b].q_ready;
            chk($sformatf("q_ready%0d", pp), 64'(rsp[pp].q_ready), 64'(exp_rdy));
            if (req[pp].q_valid && win[b] != pp) any_conf = 1'b1;
            last_rdy[pp] = rsp[pp].q_ready;
        end
        for (int bb = 0; bb < NB; bb++) begin
            chk($sformatf("mem_valid%0d", bb), 64'(mreq[bb].q_valid), 64'(win[bb] >= 0));
            if (win[bb] >= 0) begin
                w = win[bb];
                chk($sformatf("mem_row%0d", bb), 64'(mreq[bb].q.addr), m_row(req[w].q.addr));
                chk($sformatf("mem_wr_strb%0d", bb), 64'({mreq[bb].q.write, mreq[bb].q.strb}),
                    64'({req[w].q.write, req[w].q.strb}));
                chk($sformatf("mem_data%0d", bb), mreq[bb].q.data, req[w].q.data);
            end
            cap_v[bb]   = mreq[bb].q_valid;
            cap_wr[bb]  = mreq[bb].q.write;
            cap_row[bb] = mreq[bb].q.addr;
            cap_d[bb]   = mreq[bb].q.data;
            cap_s[bb]   = mreq[bb].q.strb;
            cap_rdy[bb] = mrsp[bb].q_ready;
        end
        @(posedge clk);
        // reference model: accepted requests, priority, statistics
        for (int bb = 0; bb < NB; bb++) begin
            if (win[bb] >= 0 && cap_rdy[bb]) begin
                w  = win[bb];
                wd = m_word(req[w].q.addr);
                exp_q.push_back({w[0], req[w].q.write, shadow[wd]});
                if (req[w].q.write) shadow[wd] = merge(shadow[wd], req[w].q.data, req[w].q.strb);
                rr_m[bb] = (w + 1) % NP;
            end
        end
        if (clr) cnt_m = 32'h0;
        else if (any_conf && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
        // SRAM banks answering the DUT's own bank requests
        for (int bb = 0; bb < NB; bb++) begin
            out_d[bb] = {$urandom, $urandom};
            if (cap_v[bb] && cap_rdy[bb]) begin
                if (cap_wr[bb]) sram[bb][cap_row[bb]] = merge(sram[bb][cap_row[bb]], cap_d[bb], cap_s[bb]);
                else out_d[bb] = sram[bb][cap_row[bb]];
            end
        end
        #1;
        for (int bb = 0; bb < NB; bb++) mrsp[bb].p.data = out_d[bb];
        #1;
        // scoreboard
        for (int pp = 0; pp < NP; pp++) begin
            ev_n[pp] = 0; ew[pp] = 1'b0; ed[pp] = 64'h0;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            p = int'(e[65]);
            ev_n[p]++;
            ew[p] = e[64];
            ed[p] = e[63:0];
        end
        for (int pp = 0; pp < NP; pp++) begin
            chk($sformatf("rsp_collide%0d", pp), 64'(ev_n[pp] > 1), 64'h0);
            chk($sformatf("p_valid%0d", pp), 64'(rsp[pp].p_valid), 64'(ev_n[pp] > 0));
            if (ev_n[pp] > 0 && !ew[pp]) chk($sformatf("p_data%0d", pp), rsp[pp].p.data, ed[pp]);
        end
        chk("conflict_cnt", 64'(cnt), 64'(cnt_m));
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) rr_m[b] = 0;
        cnt_m = 32'h0;
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] c0;
        logic [31:0] a;
        idle();
        clr = 1'b0;
        for (int b = 0; b < NB; b++) begin
            mrsp[b].q_ready = 1'b1;
            mrsp[b].p.data  = 64'h0;
            for (int r = 0; r < 32; r++) sram[b][r] = 64'h0;
        end
        for (int i = 0; i < 128; i++) shadow[i] = 64'h0;
        for (int p = 0; p < NP; p++) last_rdy[p] = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_pvalid0", 64'(rsp[0].p_valid), 64'h0);
        chk("rst_pvalid1", 64'(rsp[1].p_valid), 64'h0);
        chk("rst_cnt", 64'(cnt), 64'h0);
        chk("rst_mem_valid3", 64'(mreq[3].q_valid), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // write then read back through bank 3, row 0
        set_req(0, 1'b1, 32'h18, 1'b1, 64'hDEAD_BEEF, 8'hFF);
        step();
        chk("t1_wr_rsp", 64'(rsp[0].p_valid), 64'h1);
        idle(); step();
        set_req(0, 1'b1, 32'h18, 1'b0, 64'h0, 8'hFF);
        step();
        chk("t1_rd_data", rsp[0].p.data, 64'hDEAD_BEEF);
        idle(); step();

        // different banks in the same cycle
        set_req(0, 1'b1, 32'h00, 1'b0, 64'h0, 8'hFF);
        set_req(1, 1'b1, 32'h08, 1'b0, 64'h0, 8'hFF);
        c0 = cnt;
        step();
        chk("t2_both_ready", 64'({last_rdy[1], last_rdy[0]}), 64'h3);
        chk("t2_no_conflict", 64'(cnt), 64'(c0));
        idle(); step();

        // both ports hammer bank 2
        clr = 1'b1; step(); clr = 1'b0;
        set_req(0, 1'b1, 32'h10, 1'b0, 64'h0, 8'hFF);
        set_req(1, 1'b1, 32'h30, 1'b0, 64'h0, 8'hFF);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t3_grant", 64'({last_rdy[1], last_rdy[0]}), (i % 2 == 0) ? 64'h1 : 64'h2);
        end
        chk("t3_cnt", 64'(cnt), 64'd6);
        idle(); step();

        // bank 1 busy for three cycles
        mrsp[1].q_ready = 1'b0;
        set_req(1, 1'b1, 32'h08, 1'b0, 64'h0, 8'hFF);
        c0 = cnt;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_stall", 64'(last_rdy[1]), 64'h0);
            chk("t4_cnt", 64'(cnt), 64'(c0));
        end
        mrsp[1].q_ready = 1'b1;
        step();
        chk("t4_grant", 64'(last_rdy[1]), 64'h1);
        idle(); step();

        // saturation and clear priority
        force dut.conflict_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.conflict_cnt_q;
        cnt_m = 32'hFFFF_FFFE;
        set_req(0, 1'b1, 32'h10, 1'b0, 64'h0, 8'hFF);
        set_req(1, 1'b1, 32'h30, 1'b0, 64'h0, 8'hFF);
        repeat (3) step();
        chk("t5_sat", 64'(cnt), 64'hFFFF_FFFF);
        clr = 1'b1; step(); clr = 1'b0;
        chk("t5_clr", 64'(cnt), 64'h0);
        idle(); step();

        // reset while a response is in flight
        set_req(0, 1'b1, 32'h10, 1'b0, 64'h0, 8'hFF);
        set_req(1, 1'b1, 32'h30, 1'b0, 64'h0, 8'hFF);
        step();
        set_req(1, 1'b0, 32'h0, 1'b0, 64'h0, 8'h0);
        step();   // port 0 alone on bank 2: its pointer now favours port 1
        idle();
        rst_n = 1'b0;
        #1;
        chk("t6_pvalid_rst", 64'(rsp[0].p_valid), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("t6_cnt_rst", 64'(cnt), 64'h0);
        step();
        set_req(0, 1'b1, 32'h10, 1'b0, 64'h0, 8'hFF);
        set_req(1, 1'b1, 32'h30, 1'b0, 64'h0, 8'hFF);
        step();
        chk("t6_rr_rst", 64'({last_rdy[1], last_rdy[0]}), 64'h1);
        idle(); step();

        // random traffic; losers keep their request stable
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!(req[p].q_valid && !last_rdy[p])) begin
                    a = (32'($urandom_range(0, 15)) << 3) | ($urandom & 32'hFFFF_FC00);
                    set_req(p, $urandom_range(0, 3) != 0, a, 1'($urandom_range(0, 1)),
                            {$urandom, $urandom}, 8'($urandom_range(0, 255)));
                end
            end
            for (int b = 0; b < NB; b++) mrsp[b].q_ready = ($urandom_range(0, 4) != 0);
            clr = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
